cache_control: RTL
==================

# cache_control

Sequencing FSM for the 2-way, write-back, write-allocate L1 cache datapath. Accepts one CPU request at a time, performs tag compare, handles dirty-victim writeback and line fill over the physical-memory port, and drives every datapath control strobe (array reads/loads, valid/dirty/tag/LRU updates, pmem address and data-in selects). Also keeps saturating hit/miss/writeback statistics counters. Sits between the pipeline memory stage (or arbiter) and the cache datapath, one instance per cache.

## Interface
- CNT_W, 32, width of each statistics counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp; wins if both asserted
- mem_resp  out  1  one-cycle completion pulse
- hit  in  1  datapath tag-compare hit (way0 | way1)
- dirty_i  in  1  datapath dirty bit of the LRU way at current index
- pmem_resp  in  1  physical memory done (read data valid / write accepted)
- pmem_read  out  1  line read request, held until pmem_resp
- pmem_write  out  1  line write request, held until pmem_resp
- pmem_addr_sel  out  1  0 = CPU line address, 1 = datapath writeback address
- data_in_sel  out  1  0 = CPU write data/byte enables, 1 = pmem line, all 32 bytes enabled
- read_data, read_lru  out  1 each  array read enables
- load_data, load_tag, set_valid, set_dirty, clear_dirty, set_lru, set_last_used_c  out  1 each  datapath update strobes
- clear_stats  in  1  synchronous clear of statistics counters
- hit_count, miss_count, wb_count  out  CNT_W each  statistics

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL, REREAD. Outputs are Moore except the COMPARE hit strobes and the pmem_resp-qualified strobes.
- IDLE: read_data=1, read_lru=1. If mem_read|mem_write, go to COMPARE; else stay.
- COMPARE: read_data=1, read_lru=1.
  - No request (dropped): go to IDLE, no strobes.
  - hit: mem_resp=1, set_lru=1, set_last_used_c=1. Write additionally asserts load_data=1, set_dirty=1, data_in_sel=0. Go to IDLE.
  - miss with dirty_i=1: go to WRITEBACK. Miss with dirty_i=0: go to FILL.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, read_lru=1. On pmem_resp, assert clear_dirty=1 and go to FILL.
- FILL: pmem_read=1, pmem_addr_sel=0, read_lru=1. On pmem_resp, assert load_data=1, data_in_sel=1, load_tag=1, set_valid=1 and clear_dirty=1, then go to REREAD. The load targets the LRU way.
- REREAD: read_data=1, read_lru=1. Unconditionally go to COMPARE. The re-compare hits and completes the request; a write merges into the freshly filled line.
- pmem_resp outside WRITEBACK/FILL is ignored.
- miss_pending flag: set on a COMPARE miss, cleared on mem_resp.
- Counters:
  - hit_count +1 on a COMPARE hit with miss_pending=0.
  - miss_count +1 on a COMPARE miss with miss_pending=0.
  - wb_count +1 on WRITEBACK completion.
  - All counters saturate at 2^CNT_W-1. clear_stats zeroes them and wins over a same-cycle increment.

## Timing
- Reset: state IDLE, miss_pending=0, all counters 0.
  - While rst is high: mem_resp, pmem_read, pmem_write, all load/set/clear strobes and both selects are 0; read_data=1, read_lru=1.
  - rst in any state returns to IDLE on the next edge and abandons any pmem transaction (pmem_read/pmem_write drop next cycle). No datapath update occurs in the reset cycle.
- Hit latency: request first seen in IDLE at cycle 0; mem_resp at cycle 1.
- Clean-miss latency: 0 IDLE, 1 COMPARE, FILL from cycle 2 until pmem_resp at cycle 2+F, REREAD at 3+F, mem_resp at 4+F.
- Dirty miss: adds W+1 cycles, where pmem_resp arrives W cycles after WRITEBACK entry.
- pmem_read and pmem_write are never asserted together. Each is held stable, with a constant pmem_addr_sel, until pmem_resp.
- Back-to-back requests: a new request asserted in the cycle after mem_resp is taken from IDLE, so minimum issue interval is 2 cycles.

## Test plan
- Reset, then read addr 0x0000_0040 into an empty cache -> COMPARE miss, FILL, pmem_read held 5 cycles until pmem_resp, REREAD, mem_resp at cycle 4+F. miss_count=1, hit_count=0.
- Read the same address again -> mem_resp at cycle 1, set_lru pulse, hit_count=1, no pmem activity.
- Write 0xDEADBEEF to 0x0000_0044, then force eviction with a third tag at the same index -> WRITEBACK with pmem_addr_sel=1, clear_dirty on pmem_resp, then FILL. wb_count=1 and the written-back line contains 0xDEADBEEF.
- Write miss to a clean set -> FILL, REREAD, COMPARE with load_data=1, set_dirty=1, data_in_sel=0 in the mem_resp cycle.
- Assert rst mid-FILL with pmem_resp never given -> IDLE next cycle, pmem_read=0, no tag/valid load, counters reset to 0.
- Drive hit_count to 2^CNT_W-1 (CNT_W=4) -> saturates at 15. Asserting clear_stats together with a hit -> 0.

Source files
------------

// File: rtl/cache_control.sv
// cache_control
// Sequencing controller for a 2-way, write-back, write-allocate L1 cache
// datapath. It accepts one CPU request at a time and runs a tag compare.
// On a miss it writes back a dirty victim, fills the line from physical
// memory and then re-compares so the request completes as a hit. It drives
// every datapath strobe and keeps saturating hit/miss/writeback counters.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mem_read, mem_write       CPU request, held until mem_resp (write wins)
//   mem_resp                  one-cycle completion pulse
//   hit, dirty_i              datapath tag-compare hit, dirty bit of LRU way
//   pmem_resp                 physical memory done
//   pmem_read, pmem_write     line transfer requests, held until pmem_resp
//   pmem_addr_sel             0 = CPU line address, 1 = writeback address
//   data_in_sel               0 = CPU write data, 1 = pmem line (all bytes)
//   read_data, read_lru       array read enables
//   load_data, load_tag, set_valid, set_dirty, clear_dirty,
//   set_lru, set_last_used_c  datapath update strobes
//   clear_stats               synchronous clear of the statistics counters
//   hit_count, miss_count, wb_count   saturating statistics
module cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             dirty_i,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             data_in_sel,
    output logic             read_data,
    output logic             read_lru,
    output logic             load_data,
    output logic             load_tag,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             clear_dirty,
    output logic             set_lru,
    output logic             set_last_used_c,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_FILL,
        S_REREAD
    } state_t;

    state_t           state_q, state_d;
    logic             miss_pending_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       cnt_inc;

    logic req;
    logic cmp_hit;
    logic cmp_miss;
    logic wb_done;

    assign req      = mem_read | mem_write;
    assign cmp_hit  = (state_q == S_COMPARE) && req && hit;
    assign cmp_miss = (state_q == S_COMPARE) && req && !hit;
    assign wb_done  = (state_q == S_WRITEBACK) && pmem_resp;

    // Only the first compare of a request is counted; the re-compare after a
    // fill is part of the same miss.
    assign cnt_inc[0] = cmp_hit  && !miss_pending_q;
    assign cnt_inc[1] = cmp_miss && !miss_pending_q;
    assign cnt_inc[2] = wb_done;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req) state_d = S_COMPARE;
            S_COMPARE: begin
                if (!req || hit) state_d = S_IDLE;
                else if (dirty_i) state_d = S_WRITEBACK;
                else state_d = S_FILL;
            end
            S_WRITEBACK: if (pmem_resp) state_d = S_FILL;
            S_FILL:      if (pmem_resp) state_d = S_REREAD;
            S_REREAD:    state_d = S_COMPARE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode. While rst is high every strobe is held off so that no
    // datapath update or pmem request happens in the reset cycle, whatever
    // state the register still holds.
    always_comb begin
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_addr_sel   = 1'b0;
        data_in_sel     = 1'b0;
        read_data       = 1'b0;
        read_lru        = 1'b0;
        load_data       = 1'b0;
        load_tag        = 1'b0;
        set_valid       = 1'b0;
        set_dirty       = 1'b0;
        clear_dirty     = 1'b0;
        set_lru         = 1'b0;
        set_last_used_c = 1'b0;
        if (rst) begin
            read_data = 1'b1;
            read_lru  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_REREAD: begin
                    read_data = 1'b1;
                    read_lru  = 1'b1;
                end
                S_COMPARE: begin
                    read_data = 1'b1;
                    read_lru  = 1'b1;
                    if (cmp_hit) begin
                        mem_resp        = 1'b1;
                        set_lru         = 1'b1;
                        set_last_used_c = 1'b1;
                        if (mem_write) begin
                            load_data = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    read_lru      = 1'b1;
                    clear_dirty   = pmem_resp;
                end
                S_FILL: begin
                    pmem_read = 1'b1;
                    read_lru  = 1'b1;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        data_in_sel = 1'b1;
                        load_tag    = 1'b1;
                        set_valid   = 1'b1;
                        clear_dirty = 1'b1;
                    end
                end
                default: begin
                    read_data = 1'b1;
                    read_lru  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            miss_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_resp) miss_pending_q <= 1'b0;
            else if (cmp_miss) miss_pending_q <= 1'b1;
        end
    end

    // Statistics counters: clear wins over increment, increment saturates.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || clear_stats) cnt_q[gi] <= '0;
                else if (cnt_inc[gi] && !(&cnt_q[gi])) cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
            end
        end
    endgenerate

    assign hit_count  = cnt_q[0];
    assign miss_count = cnt_q[1];
    assign wb_count   = cnt_q[2];

endmodule
